usb_rx_packet_writer: RTL and testbench

- Receive-side stage that sits directly upstream of the USB packet buffer.
- Takes the decoded byte stream from the USB serial interface engine and packs the bytes little-endian into 32-bit words.
- Writes those words into the packet buffer through the buffer's USB-side write port.
- On a clean end of packet, hands buffer ownership to the core with a one-cycle got_packet pulse and the byte length.

---
 rtl/usb_rx_packet_writer_pkg.sv | 23 ++
 rtl/usb_rx_packet_writer_word_packer.sv | 47 ++++
 rtl/usb_rx_packet_writer.sv | 177 +++++++++++++++++
 tb/tb_usb_rx_packet_writer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_packet_writer_pkg.sv
// rtl/usb_rx_packet_writer_pkg.sv - shared state type, buffer default and width helpers (package usb_pkg)
package usb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECEIVE,
    DISCARD,
    FLUSH,
    COMMIT
  } rx_state_t;

  localparam int BUFFER_BYTES_DEFAULT = 1024;

  function automatic int addr_width(input int buffer_bytes);
    return (buffer_bytes > 4) ? $clog2(buffer_bytes / 4) : 1;
  endfunction

  // One extra bit so the count can hold BUFFER_BYTES itself.
  function automatic int count_width(input int buffer_bytes);
    return $clog2(buffer_bytes) + 1;
  endfunction

endpackage

// File: rtl/usb_rx_packet_writer_word_packer.sv
// rtl/usb_rx_packet_writer_word_packer.sv - packs received bytes little-endian into 32-bit words
module usb_word_packer (
  input  logic        clk48,
  input  logic        rst_n,
  input  logic [7:0]  data_byte,
  input  logic        byte_valid,
  input  logic        clear,
  output logic [31:0] word,
  output logic [1:0]  lane,
  output logic        word_full,
  output logic        partial
);

  logic [31:0] word_q;
  logic [1:0]  lane_q;
  logic        full_q;

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      lane_q <= '0;
      full_q <= 1'b0;
    end else if (clear) begin
      word_q <= '0;
      lane_q <= '0;
      full_q <= 1'b0;
    end else begin
      full_q <= byte_valid && (lane_q == 2'd3);
      if (byte_valid) begin
        lane_q <= lane_q + 2'd1;
        // Lane 0 restarts the word so a flushed partial word has zero upper lanes.
        case (lane_q)
          2'd0:    word_q <= {24'h000000, data_byte};
          2'd1:    word_q[15:8] <= data_byte;
          2'd2:    word_q[23:16] <= data_byte;
          default: word_q[31:24] <= data_byte;
        endcase
      end
    end
  end

  assign word      = word_q;
  assign lane      = lane_q;
  assign word_full = full_q;
  assign partial   = (lane_q != 2'd0);

endmodule

// File: rtl/usb_rx_packet_writer.sv
// rtl/usb_rx_packet_writer.sv - writes received USB packet bytes into the packet buffer; stats via USB_RX_PACKET_WRITER_STATS_EN
module usb_rx_packet_writer
  import usb_pkg::*;
#(
  parameter int BUFFER_BYTES = BUFFER_BYTES_DEFAULT,
  parameter int ADDR_W       = addr_width(BUFFER_BYTES)
) (
  input  logic              clk48,
  input  logic              rst_n,
  input  logic [7:0]        rx_byte,
  input  logic              rx_byte_valid,
  input  logic              rx_packet_start,
  input  logic              rx_packet_end,
  input  logic              rx_crc_ok,
  input  logic              rx_error,
  input  logic              buffer_owned_by_core,
  output logic [ADDR_W-1:0] buffer_address,
  output logic [31:0]       buffer_write_value,
  output logic              buffer_write,
  output logic              got_packet,
  output logic [31:0]       data_length
`ifdef USB_RX_PACKET_WRITER_STATS_EN
  ,
  output logic [15:0]       dropped_packets,
  output logic              overflow_seen
`endif
);

  localparam int COUNT_W = count_width(BUFFER_BYTES);
  localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(BUFFER_BYTES);

  rx_state_t state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        length_q, length_d;
  // Set when DISCARD was entered on the cycle that already carried the end strobe.
  logic               one_shot_q, one_shot_d;

  logic        pack_valid, pack_clear, overflow, write_en;
  logic [31:0] pack_word;
  logic [1:0]  pack_lane;
  logic        pack_full, pack_partial;

  usb_word_packer u_packer (
    .clk48      (clk48),
    .rst_n      (rst_n),
    .data_byte  (rx_byte),
    .byte_valid (pack_valid),
    .clear      (pack_clear),
    .word       (pack_word),
    .lane       (pack_lane),
    .word_full  (pack_full),
    .partial    (pack_partial)
  );

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      addr_q     <= '0;
      length_q   <= '0;
      one_shot_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      length_q   <= length_d;
      one_shot_q <= one_shot_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    addr_d     = addr_q;
    length_d   = length_q;
    one_shot_d = one_shot_q;
    pack_valid = 1'b0;
    pack_clear = 1'b0;
    overflow   = 1'b0;
    write_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_packet_start) begin
          pack_clear = 1'b1;
          count_d    = '0;
          addr_d     = '0;
          one_shot_d = 1'b0;
          state_d    = buffer_owned_by_core ? DISCARD : RECEIVE;
        end
      end

      RECEIVE: begin
        write_en = pack_full;
        if (write_en) addr_d = addr_q + ADDR_W'(1);
        if (rx_packet_start) begin
          pack_clear = 1'b1;
          count_d    = '0;
          addr_d     = '0;
          one_shot_d = 1'b0;
          state_d    = buffer_owned_by_core ? DISCARD : RECEIVE;
        end else if (rx_error) begin
          one_shot_d = rx_packet_end;
          state_d    = DISCARD;
        end else begin
          if (rx_byte_valid) begin
            if (count_q == COUNT_MAX) begin
              overflow   = 1'b1;
              one_shot_d = rx_packet_end;
              state_d    = DISCARD;
            end else begin
              pack_valid = 1'b1;
              count_d    = count_q + COUNT_W'(1);
            end
          end
          if (rx_packet_end && !overflow) begin
            if (!rx_crc_ok) begin
              one_shot_d = 1'b1;
              state_d    = DISCARD;
            end else if (pack_valid || pack_partial) begin
              state_d = FLUSH;
            end else begin
              length_d = {{(32-COUNT_W){1'b0}}, count_q};
              state_d  = COMMIT;
            end
          end
        end
      end

      DISCARD: begin
        if (one_shot_q || rx_packet_end || rx_error) begin
          one_shot_d = 1'b0;
          state_d    = IDLE;
        end
      end

      FLUSH: begin
        // The pending word is either a just-completed word or a zero-padded partial one.
        write_en = pack_full || pack_partial;
        if (write_en) addr_d = addr_q + ADDR_W'(1);
        length_d = {{(32-COUNT_W){1'b0}}, count_q};
        state_d  = COMMIT;
      end

      COMMIT: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign buffer_write       = write_en;
  assign buffer_address     = addr_q;
  assign buffer_write_value = pack_word;
  assign got_packet         = (state_q == COMMIT);
  assign data_length        = length_q;

`ifdef USB_RX_PACKET_WRITER_STATS_EN
  logic [15:0] dropped_q;
  logic        overflow_q;

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      dropped_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if ((state_d == DISCARD) && (state_q != DISCARD) && (dropped_q != 16'hFFFF))
        dropped_q <= dropped_q + 16'd1;
      if (overflow) overflow_q <= 1'b1;
    end
  end

  assign dropped_packets = dropped_q;
  assign overflow_seen   = overflow_q;
`endif

endmodule

// File: tb/tb_usb_rx_packet_writer.sv
// tb/tb_usb_rx_packet_writer.sv - self-checking bench for usb_rx_packet_writer
module tb_usb_rx_packet_writer;

  localparam int BB = 1024;
  localparam int AW = 8;

  logic          clk48 = 1'b0;
  logic          rst_n;
  logic [7:0]    rx_byte;
  logic          rx_byte_valid, rx_packet_start, rx_packet_end, rx_crc_ok, rx_error;
  logic          buffer_owned_by_core;
  logic [AW-1:0] buffer_address;
  logic [31:0]   buffer_write_value;
  logic          buffer_write, got_packet;
  logic [31:0]   data_length;
`ifdef USB_RX_PACKET_WRITER_STATS_EN
  logic [15:0]   dropped_packets;
  logic          overflow_seen;
`endif

  always #10 clk48 = ~clk48;

  usb_rx_packet_writer #(.BUFFER_BYTES(BB)) dut (
    .clk48                (clk48),
    .rst_n                (rst_n),
    .rx_byte              (rx_byte),
    .rx_byte_valid        (rx_byte_valid),
    .rx_packet_start      (rx_packet_start),
    .rx_packet_end        (rx_packet_end),
    .rx_crc_ok            (rx_crc_ok),
    .rx_error             (rx_error),
    .buffer_owned_by_core (buffer_owned_by_core),
    .buffer_address       (buffer_address),
    .buffer_write_value   (buffer_write_value),
    .buffer_write         (buffer_write),
    .got_packet           (got_packet),
    .data_length          (data_length)
`ifdef USB_RX_PACKET_WRITER_STATS_EN
    ,
    .dropped_packets      (dropped_packets),
    .overflow_seen        (overflow_seen)
`endif
  );

  int checks = 0;
  int errors = 0;
  int model_len = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  // Observed buffer traffic and commits
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          commits[$];
  int          cyc = 0;
  int          last_wr_cyc = -10;

  always @(negedge clk48) begin
    cyc++;
    if (rst_n && buffer_write) begin
      wr_addr.push_back(int'(buffer_address));
      wr_data.push_back(buffer_write_value);
      last_wr_cyc = cyc;
    end
    if (rst_n && got_packet) begin
      commits.push_back(int'(data_length));
      chk("commit_after_last_write", int'(last_wr_cyc < cyc), 1);
    end
  end

  logic [7:0] pkt[$];

  task automatic clear_obs();
    wr_addr.delete();
    wr_data.delete();
    commits.delete();
  endtask

  task automatic drive(input logic [7:0] b, input logic v, input logic s, input logic e,
                       input logic c, input logic err);
    rx_byte = b; rx_byte_valid = v; rx_packet_start = s;
    rx_packet_end = e; rx_crc_ok = c; rx_error = err;
    @(posedge clk48);
    #1;
    rx_byte_valid = 1'b0; rx_packet_start = 1'b0; rx_packet_end = 1'b0;
    rx_crc_ok = 1'b0; rx_error = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_pkt(input logic owned, input logic crc, input logic merge,
                          input int err_at, input logic gaps);
    buffer_owned_by_core = owned;
    drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    buffer_owned_by_core = ~owned;
    for (int i = 0; i < pkt.size(); i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) idle(1);
      if (merge && (i == pkt.size() - 1) && (err_at < 0))
        drive(pkt[i], 1'b1, 1'b0, 1'b1, crc, 1'b0);
      else
        drive(pkt[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == err_at) drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    if (!(merge && (pkt.size() > 0) && (err_at < 0)))
      drive(8'h00, 1'b0, 1'b0, 1'b1, crc, 1'b0);
    idle(3);
    buffer_owned_by_core = 1'b0;
  endtask

  function automatic logic [31:0] model_word(input int k);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++)
      if (4 * k + j < pkt.size()) w[8*j +: 8] = pkt[4*k+j];
    return w;
  endfunction

  // kind: 0 committed, 1 dropped after reception started, 2 dropped for ownership
  task automatic check_model(input string nm, input int kind);
    int nw;
    nw = (pkt.size() + 3) / 4;
    if (kind == 0) begin
      chk({nm, "_writes"}, wr_addr.size(), nw);
      chk({nm, "_commits"}, commits.size(), 1);
      if (commits.size() > 0) chk({nm, "_commit_len"}, commits[0], pkt.size());
      model_len = pkt.size();
    end else begin
      chk({nm, "_commits"}, commits.size(), 0);
      if (kind == 2) chk({nm, "_writes"}, wr_addr.size(), 0);
      else chk({nm, "_writes_bound"}, int'(wr_addr.size() <= pkt.size() / 4), 1);
    end
    chk({nm, "_data_length"}, int'(data_length), model_len);
    for (int k = 0; k < wr_addr.size(); k++) begin
      chk({nm, "_addr"}, wr_addr[k], k);
      chk({nm, "_word"}, int'(wr_data[k]), int'(model_word(k)));
    end
  endtask

  typedef struct {
    logic        owned;
    int          n;
    logic        crc;
    logic        merge;
    logic [7:0]  first;
    logic [7:0]  step;
    int          exp_writes;
    logic        exp_commit;
    int          exp_len;
    logic [31:0] exp_w0;
    logic [31:0] exp_wlast;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_drop;
    vecs[0] = '{1'b0, 8, 1'b1, 1'b0, 8'h11, 8'h01, 2, 1'b1, 8, 32'h14131211, 32'h18171615};
    vecs[1] = '{1'b0, 3, 1'b1, 1'b0, 8'hA1, 8'h11, 1, 1'b1, 3, 32'h00C3B2A1, 32'h0};
    vecs[2] = '{1'b0, 5, 1'b0, 1'b0, 8'h30, 8'h01, 1, 1'b0, 3, 32'h33323130, 32'h0};
    vecs[3] = '{1'b1, 4, 1'b1, 1'b0, 8'h50, 8'h01, 0, 1'b0, 3, 32'h0, 32'h0};
    vecs[4] = '{1'b0, 0, 1'b1, 1'b0, 8'h00, 8'h00, 0, 1'b1, 0, 32'h0, 32'h0};
    vecs[5] = '{1'b0, 4, 1'b1, 1'b1, 8'h01, 8'h01, 1, 1'b1, 4, 32'h04030201, 32'h0};
    vecs[6] = '{1'b0, 1, 1'b1, 1'b0, 8'hEE, 8'h00, 1, 1'b1, 1, 32'h000000EE, 32'h0};
    vecs[7] = '{1'b0, 8, 1'b0, 1'b1, 8'h40, 8'h01, 1, 1'b0, 1, 32'h43424140, 32'h0};

    rst_n = 1'b0;
    rx_byte = '0; rx_byte_valid = 0; rx_packet_start = 0; rx_packet_end = 0;
    rx_crc_ok = 0; rx_error = 0; buffer_owned_by_core = 0;
    #25;
    chk("reset_write", int'(buffer_write), 0);
    chk("reset_got_packet", int'(got_packet), 0);
    chk("reset_data_length", int'(data_length), 0);
    chk("reset_address", int'(buffer_address), 0);
    chk("reset_value", int'(buffer_write_value), 0);
`ifdef USB_RX_PACKET_WRITER_STATS_EN
    chk("reset_dropped", int'(dropped_packets), 0);
    chk("reset_overflow", int'(overflow_seen), 0);
`endif
    @(negedge clk48);
    rst_n = 1'b1;
    @(posedge clk48);
    #1;

    // Directed vector table
    for (int v = 0; v < 8; v++) begin
      pkt.delete();
      for (int i = 0; i < vecs[v].n; i++) pkt.push_back(vecs[v].first + 8'(i) * vecs[v].step);
      clear_obs();
      send_pkt(vecs[v].owned, vecs[v].crc, vecs[v].merge, -1, 1'b0);
      chk($sformatf("vec%0d_writes", v), wr_addr.size(), vecs[v].exp_writes);
      chk($sformatf("vec%0d_commits", v), commits.size(), int'(vecs[v].exp_commit));
      chk($sformatf("vec%0d_data_length", v), int'(data_length), vecs[v].exp_len);
      if (vecs[v].exp_commit && commits.size() > 0)
        chk($sformatf("vec%0d_commit_len", v), commits[0], vecs[v].exp_len);
      if (vecs[v].exp_writes > 0 && wr_data.size() > 0) begin
        chk($sformatf("vec%0d_addr0", v), wr_addr[0], 0);
        chk($sformatf("vec%0d_word0", v), int'(wr_data[0]), int'(vecs[v].exp_w0));
      end
      if (vecs[v].exp_writes > 1 && wr_data.size() == vecs[v].exp_writes) begin
        chk($sformatf("vec%0d_addr_last", v), wr_addr[wr_addr.size()-1], vecs[v].exp_writes - 1);
        chk($sformatf("vec%0d_word_last", v), int'(wr_data[wr_data.size()-1]), int'(vecs[v].exp_wlast));
      end
      if (vecs[v].exp_commit) model_len = vecs[v].exp_len;
    end

    // Overflow: one byte more than the buffer holds
    pkt.delete();
    for (int i = 0; i < BB + 1; i++) pkt.push_back(8'(i * 7 + 3));
    clear_obs();
    send_pkt(1'b0, 1'b1, 1'b0, -1, 1'b0);
    chk("ovf_writes", wr_addr.size(), BB / 4);
    chk("ovf_commits", commits.size(), 0);
    chk("ovf_data_length", int'(data_length), model_len);
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < wr_addr.size(); k++)
        if (wr_addr[k] != k || wr_data[k] != model_word(k)) bad++;
      chk("ovf_word_contents_bad", bad, 0);
    end
`ifdef USB_RX_PACKET_WRITER_STATS_EN
    chk("ovf_overflow_seen", int'(overflow_seen), 1);
`endif

    // Restart inside RECEIVE abandons the first packet
    drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(8'h91, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(8'h92, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(8'h93, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pkt.delete();
    pkt.push_back(8'h55); pkt.push_back(8'h66);
    clear_obs();
    send_pkt(1'b0, 1'b1, 1'b0, -1, 1'b0);
    check_model("restart", 0);

    // Restart redoes the ownership check
`ifdef USB_RX_PACKET_WRITER_STATS_EN
    prev_drop = int'(dropped_packets);
`else
    prev_drop = 0;
`endif
    drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(8'hA0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(8'hA1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pkt.delete();
    for (int i = 0; i < 4; i++) pkt.push_back(8'hC0 + 8'(i));
    clear_obs();
    send_pkt(1'b1, 1'b1, 1'b0, -1, 1'b0);
    check_model("restart_owned", 2);
`ifdef USB_RX_PACKET_WRITER_STATS_EN
    chk("restart_owned_dropped", int'(dropped_packets), prev_drop + 1);
`endif

    // rx_error aborts mid-packet
    pkt.delete();
    for (int i = 0; i < 6; i++) pkt.push_back(8'h70 + 8'(i));
    clear_obs();
    send_pkt(1'b0, 1'b1, 1'b0, 5, 1'b0);
    check_model("rx_error", 1);

    // Reset in the middle of a packet
    drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(8'h20 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("midrst_address", int'(buffer_address), 0);
    chk("midrst_data_length", int'(data_length), 0);
    chk("midrst_value", int'(buffer_write_value), 0);
    chk("midrst_write", int'(buffer_write), 0);
    model_len = 0;
    @(negedge clk48);
    rst_n = 1'b1;
    @(posedge clk48);
    #1;
    pkt.delete();
    for (int i = 0; i < 4; i++) pkt.push_back(8'hD0 + 8'(i));
    clear_obs();
    send_pkt(1'b0, 1'b1, 1'b0, -1, 1'b0);
    check_model("after_reset", 0);

    // Randomised packets against the reference model
    for (int p = 0; p < 40; p++) begin
      logic owned, crc, merge;
      int n, err_at, kind;
      n      = $urandom_range(0, 20);
      owned  = ($urandom_range(0, 5) == 0);
      crc    = ($urandom_range(0, 3) != 0);
      merge  = $urandom_range(0, 1);
      err_at = (n > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
      clear_obs();
      send_pkt(owned, crc, merge, err_at, 1'b1);
      kind = owned ? 2 : ((!crc || err_at >= 0) ? 1 : 0);
      check_model($sformatf("rand%0d", p), kind);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
